sm3_msg_pad: RTL

//  Upstream feeder for the SM3 hash stage. Accepts a message as a stream of 32-bit big-endian words,

---
 rtl/sm3_msg_pad.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sm3_msg_pad.sv
// SM3 message padder: packs 32-bit big-endian words into 512-bit blocks with 0x80, zero fill and bit length.
// Optional SM3_PAD_RAW_EN adds raw_mode for pre-padded data (blocks pass through, no padding or length).
module sm3_msg_pad #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_bytes,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
`ifdef SM3_PAD_RAW_EN
  input  logic         raw_mode,
`endif
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic         blk_valid,
  input  logic         blk_ready
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_PAD   = 2'd1;
  localparam logic [1:0] S_EXTRA = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       after;
  logic             run;
  logic [3:0]       wc;
  logic [LEN_W-1:0] bits;
  logic [LEN_W-1:0] bits_nxt;
  logic [63:0]      len_nxt;
  logic [63:0]      len_cur;
  logic [6:0]       b;
  logic [31:0]      keep_mask;
  logic [31:0]      marker;
  logic [31:0]      last_word;
  logic             raw_eff;
  logic             acc;

  assign in_ready  = run & (state == S_FILL);
  assign blk_valid = (state == S_EMIT);
  assign acc       = in_valid & in_ready;

  assign bits_nxt = bits + LEN_W'({in_bytes, 3'b000});
  assign len_nxt  = 64'(bits_nxt);
  assign len_cur  = 64'(bits);
  assign b        = {1'b0, wc, 2'b00} + {4'b0000, in_bytes};

  // Keep the valid MSB-aligned bytes; the 0x80 marker lands on the first byte after them.
  assign keep_mask = ~(32'hFFFF_FFFF >> {in_bytes, 3'b000});
  assign marker    = 32'h8000_0000 >> {in_bytes, 3'b000};
  assign last_word = (in_data & keep_mask) | (raw_eff ? 32'h0 : marker);

`ifdef SM3_PAD_RAW_EN
  logic first;
  logic raw_q;

  assign raw_eff = first ? raw_mode : raw_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first <= 1'b1;
      raw_q <= 1'b0;
    end else if (acc) begin
      first <= 1'b0;
      raw_q <= raw_eff;
    end else if (state == S_EMIT && blk_ready && blk_last) begin
      first <= 1'b1;
    end
  end
`else
  assign raw_eff = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run      <= 1'b0;
      state    <= S_FILL;
      after    <= S_FILL;
      wc       <= 4'd0;
      bits     <= '0;
      blk_data <= '0;
      blk_last <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FILL: begin
          if (acc) begin
            bits <= bits_nxt;
            wc   <= wc + 4'd1;
            if (!in_last) begin
              blk_data[511 - 32*wc -: 32] <= in_data;
              if (wc == 4'd15) begin
                state    <= S_EMIT;
                after    <= S_FILL;
                blk_last <= 1'b0;
              end
            end else begin
              wc    <= 4'd0;
              state <= S_EMIT;
              // Words below wc already hold this block's data; everything from wc upward is rewritten.
              for (int i = 0; i < 16; i++) begin
                if (4'(i) == wc)
                  blk_data[511 - 32*i -: 32] <= last_word;
                else if (4'(i) > wc)
                  blk_data[511 - 32*i -: 32] <=
                    (!raw_eff && in_bytes == 3'd4 && 4'(i) == wc + 4'd1) ? 32'h8000_0000 : 32'h0;
              end
              if (raw_eff || b <= 7'd55) begin
                after    <= S_FILL;
                blk_last <= 1'b1;
                if (!raw_eff)
                  blk_data[63:0] <= len_nxt;
              end else if (b <= 7'd63) begin
                after    <= S_EXTRA;
                blk_last <= 1'b0;
              end else begin
                after    <= S_PAD;
                blk_last <= 1'b0;
              end
            end
          end
        end
        S_PAD: begin
          blk_data <= {32'h8000_0000, 416'd0, len_cur};
          blk_last <= 1'b1;
          after    <= S_FILL;
          state    <= S_EMIT;
        end
        S_EXTRA: begin
          blk_data <= {448'd0, len_cur};
          blk_last <= 1'b1;
          after    <= S_FILL;
          state    <= S_EMIT;
        end
        default: begin
          if (blk_ready) begin
            state <= after;
            if (blk_last) begin
              bits <= '0;
              wc   <= 4'd0;
            end
          end
        end
      endcase
    end
  end

endmodule
